// File: rtl/div_otf_convert_if.sv
// Handshake bundle for the on-the-fly quotient converter: digit/remainder
// inputs from the digit-selection stage and the converted quotient outputs.
interface div_otf_convert_if #(
  parameter int NDIG = 6
);
  localparam int QW = 2 * NDIG;
  localparam int CW = $clog2(NDIG + 1);

  logic          start;
  logic          dig_valid;
  logic [2:0]    digit;
  logic          rem_valid;
  logic          rem_neg;
  logic          busy;
  logic          done;
  logic [QW-1:0] quot;
  logic [CW-1:0] dig_cnt;
  logic          err;

  modport master (
    output start, dig_valid, digit, rem_valid, rem_neg,
    input  busy, done, quot, dig_cnt, err
  );

  modport slave (
    input  start, dig_valid, digit, rem_valid, rem_neg,
    output busy, done, quot, dig_cnt, err
  );
endinterface

// File: rtl/div_otf_convert.sv
// On-the-fly conversion of radix-4 signed quotient digits (-2..+2) into a
// two's-complement quotient. Q and QM = Q-1 are built in parallel so each
// digit is a shift/append with no carry chain; the final remainder sign
// picks Q or QM.
// Optional macro DIV_OTF_ERRCHK_EN: builds a sticky illegal-digit flag.
module div_otf_convert #(
  parameter int NDIG = 6
) (
  input  logic             clk,
  input  logic             rst,
  div_otf_convert_if.slave bus
);
  localparam int QW = 2 * NDIG;
  localparam int CW = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, CORR} state_t;

  state_t        state, state_nxt;
  logic [QW-1:0] q_r, qm_r, q_nxt, qm_nxt;
  logic [QW-1:0] quot_r;
  logic [CW-1:0] cnt_r;
  logic          busy_r, done_r;
  logic          illegal;
  logic [2:0]    dsan;
  logic          d_neg, d_pos;
  logic          accept, finish;

  // Sanitize digit: the three out-of-range codes convert as 0, then form
  // the appended Q/QM values. Append bits are q mod 4 and (q-1) mod 4; only
  // the source register (Q or QM) depends on the digit sign.
  always_comb begin
    illegal = (bus.digit == 3'b011) || (bus.digit == 3'b100) || (bus.digit == 3'b101);
    dsan    = illegal ? 3'd0 : bus.digit;
    d_neg   = dsan[2];
    d_pos   = !dsan[2] && (dsan != 3'd0);
    q_nxt   = {(d_neg ? qm_r[QW-3:0] : q_r[QW-3:0]), dsan[1:0]};
    qm_nxt  = {(d_pos ? q_r[QW-3:0] : qm_r[QW-3:0]), dsan[1:0] - 2'd1};
  end

  // Next-state logic; Start overrides everything else in any state.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    if (bus.start) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.dig_valid) begin
            accept = 1'b1;
            if (cnt_r == CW'(NDIG - 1)) state_nxt = CORR;
          end
        end
        CORR: begin
          if (bus.rem_valid) begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // State, accumulators, digit count and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      q_r    <= '0;
      qm_r   <= '1;
      quot_r <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_r <= (state_nxt != IDLE);
      done_r <= finish;
      if (bus.start) begin
        q_r   <= '0;
        qm_r  <= '1;
        cnt_r <= '0;
      end else if (accept) begin
        q_r   <= q_nxt;
        qm_r  <= qm_nxt;
        cnt_r <= cnt_r + CW'(1);
      end
      if (finish) quot_r <= bus.rem_neg ? qm_r : q_r;
    end
  end

`ifdef DIV_OTF_ERRCHK_EN
  logic err_r;

  // Sticky illegal-digit flag, cleared only by Start or reset.
  always_ff @(posedge clk) begin
    if (rst)                     err_r <= 1'b0;
    else if (bus.start)          err_r <= 1'b0;
    else if (accept && illegal)  err_r <= 1'b1;
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.quot    = quot_r;
  assign bus.dig_cnt = cnt_r;
endmodule

// File: tb/tb_div_otf_convert.sv
// Self-checking bench for div_otf_convert (NDIG=6, QW=12). The reference
// quotient is the plain integer sum of digit*4^k minus the correction ulp.
module tb_div_otf_convert;
  localparam int NDIG = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  div_otf_convert_if #(.NDIG(NDIG)) bus();
  div_otf_convert #(.NDIG(NDIG)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Digit value of a 3-bit code; out-of-range codes count as zero.
  function automatic int eff(input logic [2:0] c);
    case (c)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b110:  return -2;
      3'b111:  return -1;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_bad(input logic [2:0] c);
    return (c == 3'b011) || (c == 3'b100) || (c == 3'b101);
  endfunction

  function automatic logic [11:0] model(input logic [2:0] c [6], input bit rn);
    int          v;
    logic [31:0] t;
    v = 0;
    for (int i = 0; i < NDIG; i++) v = v * 4 + eff(c[i]);
    v = v - int'(rn);
    t = v;
    return t[11:0];
  endfunction

  function automatic bit model_err(input logic [2:0] c [6]);
    bit e;
    e = 0;
`ifdef DIV_OTF_ERRCHK_EN
    for (int i = 0; i < NDIG; i++) if (is_bad(c[i])) e = 1;
`endif
    return e;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.start = 0; bus.dig_valid = 0; bus.digit = 0;
    bus.rem_valid = 0; bus.rem_neg = 0;
  endtask

  // Start, then feed six digits with random gaps (random RemValid in gaps).
  task automatic run_digits(input logic [2:0] c [6], input int mingap, input int maxgap,
                            output int lat, output bit early);
    int g;
    bus.start = 1; cycle(); bus.start = 0;
    lat = 1; early = 0;
    for (int i = 0; i < NDIG; i++) begin
      g = $urandom_range(maxgap, mingap);
      for (int k = 0; k < g; k++) begin
        bus.dig_valid = 0; bus.digit = 3'($urandom);
        bus.rem_valid = 1'($urandom); bus.rem_neg = 1'($urandom);
        cycle(); lat++;
        if (bus.done) early = 1;
      end
      bus.dig_valid = 1; bus.digit = c[i]; bus.rem_valid = 0;
      cycle(); lat++;
      if (bus.done) early = 1;
    end
    bus.dig_valid = 0;
  endtask

  task automatic run_finish(input bit rn, output logic [11:0] q_obs, output bit d_now,
                            output bit d_after, output int lat_inc);
    bus.rem_valid = 1; bus.rem_neg = rn;
    cycle();
    d_now = bus.done; q_obs = bus.quot; lat_inc = 1;
    bus.rem_valid = 0; bus.rem_neg = 0;
    cycle();
    d_after = bus.done;
  endtask

  task automatic test_reset();
    idle_in(); rst = 1; cycle(); cycle(); rst = 0;
    checks++;
    if (bus.busy !== 0 || bus.done !== 0 || bus.quot !== 12'h0 || bus.dig_cnt !== 0 || bus.err !== 0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b quot=%h cnt=%0d err=%b, want 0 0 000 0 0",
               bus.busy, bus.done, bus.quot, bus.dig_cnt, bus.err);
    end
  endtask

  task automatic test_directed();
    logic [2:0] c [6];
    logic [11:0] q; bit dn, da, early; int lat, li;
    c = '{3'b001, 3'b110, 3'b000, 3'b000, 3'b000, 3'b000};
    for (int rn = 0; rn < 2; rn++) begin
      run_digits(c, 0, 0, lat, early);
      run_finish(rn[0], q, dn, da, li);
      checks++;
      if (q !== (rn ? 12'h1FF : 12'h200) || q !== model(c, rn[0])) begin
        errors++; $display("FAIL directed_rn%0d: quot=%h want %h", rn, q, rn ? 12'h1FF : 12'h200);
      end
      checks++;
      if (dn !== 1 || da !== 0 || early !== 0) begin
        errors++; $display("FAIL directed_done%0d: pulse=%b after=%b early=%b want 1 0 0", rn, dn, da, early);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] c [6];
    logic [11:0] q; bit dn, da, early; int lat, li;
    c = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
    run_digits(c, 0, 0, lat, early);
    run_finish(0, q, dn, da, li);
    lat += li;
    checks++;
    if (q !== 12'hAAB) begin errors++; $display("FAIL b2b_quot: quot=%h want aab", q); end
    checks++;
    if (lat != NDIG + 2 || dn !== 1) begin
      errors++; $display("FAIL b2b_latency: cycles=%0d done=%b want %0d 1", lat, dn, NDIG + 2);
    end
  endtask

  task automatic test_gaps();
    logic [2:0] c [6];
    logic [11:0] q; bit dn, da, early; int lat, li;
    c = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
    run_digits(c, 1, 3, lat, early);
    for (int k = 0; k < 3; k++) begin
      bus.dig_valid = 1; bus.digit = 3'b001; cycle();
    end
    bus.dig_valid = 0;
    checks++;
    if (bus.dig_cnt !== 6 || bus.busy !== 1 || bus.done !== 0) begin
      errors++; $display("FAIL gaps_corr_hold: cnt=%0d busy=%b done=%b want 6 1 0", bus.dig_cnt, bus.busy, bus.done);
    end
    run_finish(0, q, dn, da, li);
    checks++;
    if (q !== 12'hAAA || dn !== 1 || early !== 0) begin
      errors++; $display("FAIL gaps_quot: quot=%h done=%b early=%b want aaa 1 0", q, dn, early);
    end
  endtask

  task automatic test_reset_mid();
    bus.start = 1; cycle(); bus.start = 0;
    for (int i = 0; i < 3; i++) begin bus.dig_valid = 1; bus.digit = 3'b001; cycle(); end
    rst = 1; bus.dig_valid = 0; cycle(); rst = 0;
    checks++;
    if (bus.busy !== 0 || bus.dig_cnt !== 0 || bus.quot !== 12'h0 || bus.done !== 0) begin
      errors++; $display("FAIL reset_mid: busy=%b cnt=%0d quot=%h done=%b want 0 0 000 0",
                         bus.busy, bus.dig_cnt, bus.quot, bus.done);
    end
    for (int i = 0; i < 4; i++) begin bus.dig_valid = 1; bus.digit = 3'b010; bus.rem_valid = 1; cycle(); end
    idle_in();
    checks++;
    if (bus.busy !== 0 || bus.dig_cnt !== 0 || bus.done !== 0) begin
      errors++; $display("FAIL idle_ignore: busy=%b cnt=%0d done=%b want 0 0 0", bus.busy, bus.dig_cnt, bus.done);
    end
  endtask

  task automatic test_restart_in_corr();
    logic [2:0] c [6], c2 [6];
    logic [11:0] q, q0; bit dn, da, early; int lat, li;
    c  = '{3'b001, 3'b111, 3'b010, 3'b000, 3'b110, 3'b001};
    c2 = '{3'b110, 3'b010, 3'b000, 3'b001, 3'b111, 3'b000};
    run_digits(c, 0, 1, lat, early);
    run_finish(0, q0, dn, da, li);
    run_digits(c2, 0, 0, lat, early);
    bus.start = 1; bus.rem_valid = 1; cycle(); bus.start = 0; bus.rem_valid = 0;
    checks++;
    if (bus.done !== 0 || bus.dig_cnt !== 0 || bus.busy !== 1 || bus.quot !== model(c, 0)) begin
      errors++; $display("FAIL restart_corr: done=%b cnt=%0d busy=%b quot=%h want 0 0 1 %h",
                         bus.done, bus.dig_cnt, bus.busy, bus.quot, model(c, 0));
    end
    for (int i = 0; i < NDIG; i++) begin bus.dig_valid = 1; bus.digit = c2[i]; cycle(); end
    bus.dig_valid = 0;
    checks++;
    if (bus.quot !== q0) begin errors++; $display("FAIL restart_hold: quot=%h want %h", bus.quot, q0); end
    run_finish(1, q, dn, da, li);
    checks++;
    if (q !== model(c2, 1) || dn !== 1) begin
      errors++; $display("FAIL restart_new: quot=%h done=%b want %h 1", q, dn, model(c2, 1));
    end
  endtask

  task automatic test_errchk();
    logic [2:0] c [6];
    logic [11:0] q; bit dn, da; int li;
    bit exp_e;
    c = '{3'b001, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000};
`ifdef DIV_OTF_ERRCHK_EN
    exp_e = 1;
`else
    exp_e = 0;
`endif
    bus.start = 1; cycle(); bus.start = 0;
    bus.dig_valid = 1; bus.digit = c[0]; cycle();
    checks++;
    if (bus.err !== 0) begin errors++; $display("FAIL err_before: err=%b want 0", bus.err); end
    bus.digit = c[1]; cycle();
    checks++;
    if (bus.err !== exp_e) begin errors++; $display("FAIL err_set: err=%b want %b", bus.err, exp_e); end
    for (int i = 2; i < NDIG; i++) begin bus.digit = c[i]; cycle(); end
    bus.dig_valid = 0;
    run_finish(0, q, dn, da, li);
    checks++;
    if (q !== 12'h400 || bus.err !== exp_e) begin
      errors++; $display("FAIL err_quot: quot=%h err=%b want 400 %b", q, bus.err, exp_e);
    end
    bus.start = 1; cycle(); bus.start = 0;
    checks++;
    if (bus.err !== 0) begin errors++; $display("FAIL err_clear: err=%b want 0", bus.err); end
  endtask

  task automatic test_random();
    logic [2:0] c [6];
    logic [11:0] q; bit dn, da, early, rn; int lat, li;
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NDIG; i++) c[i] = 3'($urandom_range(7, 0));
      rn = 1'($urandom);
      run_digits(c, 0, 2, lat, early);
      run_finish(rn, q, dn, da, li);
      checks++;
      if (q !== model(c, rn) || dn !== 1 || da !== 0 || early !== 0 || bus.err !== model_err(c)) begin
        errors++;
        $display("FAIL random%0d: quot=%h done=%b/%b early=%b err=%b want %h 1/0 0 %b",
                 n, q, dn, da, early, bus.err, model(c, rn), model_err(c));
      end
    end
  endtask

  initial begin
    idle_in();
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    test_gaps();
    test_restart_in_corr();
    test_errchk();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
